// File: rtl/aq_djpeg_dhtseg.sv
`default_nettype none
// ============================================================================
// Module      : aq_djpeg_dhtseg
// Description : JPEG DHT segment parser; writes BITS counts and HUFFVAL symbols
//               to the Huffman table RAM. Define AQ_DJPEG_DHTSEG_CHECK_EN to
//               enable segment checking and the sticky SegError flag.
// Revision    : 1.0 - initial release
// ============================================================================
module aq_djpeg_dhtseg (
    input  logic       clk,
    input  logic       rst,
    input  logic       SegStart,
    input  logic       ByteValid,
    input  logic [7:0] ByteData,
    output logic       ByteReady,
    output logic       DataInEnable,
    output logic [1:0] DataInColor,
    output logic [7:0] DataInCount,
    output logic [7:0] DataIn,
    output logic       BitsEnable,
    output logic [1:0] BitsColor,
    output logic [3:0] BitsIndex,
    output logic [7:0] BitsData,
    output logic       SegDone,
    output logic       SegError
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LENH = 3'd1,
        LENL = 3'd2,
        TCTH = 3'd3,
        BITS = 3'd4,
        VALS = 3'd5,
        ERR  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [7:0]  r_lenH;
    logic [15:0] r_remaining;
    logic [11:0] r_sum;
    logic [3:0]  r_index;
    logic [7:0]  r_count;
    logic [1:0]  r_color;

    logic        w_accept;
    logic [15:0] w_length;
    logic        w_lastByte;
    logic [11:0] w_newSum;
    logic [11:0] w_sumCap;
    logic        w_lastVal;
    logic        w_bitsWr;
    logic        w_valsWr;
    logic        w_done;
    logic        w_error;

    assign ByteReady  = (r_state inside {LENH, LENL, TCTH, BITS, VALS});
    assign w_accept   = ByteValid & ByteReady;
    assign w_length   = {r_lenH, ByteData};
    assign w_lastByte = (r_remaining == 16'd1);
    assign w_newSum   = r_sum + {4'd0, ByteData};
    assign w_sumCap   = (w_newSum > 12'd256) ? 12'd256 : w_newSum;
    assign w_lastVal  = ({4'd0, r_count} == (r_sum - 12'd1));

`ifdef AQ_DJPEG_DHTSEG_CHECK_EN
    logic w_tableEnd;
    assign w_tableEnd = (r_index == 4'd15) && (w_newSum == 12'd0);
`endif

    always_comb begin
        w_nextState = r_state;
        w_bitsWr    = 1'b0;
        w_valsWr    = 1'b0;
        w_done      = 1'b0;
        w_error     = 1'b0;
        if (SegStart) begin
            w_nextState = LENH;
        end else if (w_accept) begin
            case (r_state)
                LENH: w_nextState = LENL;
                LENL: begin
                    if (w_length > 16'd2) begin
                        w_nextState = TCTH;
                    end else begin
                        w_nextState = IDLE;
                        w_done      = 1'b1;
                    end
`ifdef AQ_DJPEG_DHTSEG_CHECK_EN
                    if (w_length < 16'd2) begin
                        w_nextState = ERR;
                        w_done      = 1'b0;
                        w_error     = 1'b1;
                    end
`endif
                end
                TCTH: begin
                    w_nextState = w_lastByte ? IDLE : BITS;
                    w_done      = w_lastByte;
`ifdef AQ_DJPEG_DHTSEG_CHECK_EN
                    if ((ByteData[7:4] > 4'd1) || (ByteData[3:0] > 4'd1) || w_lastByte) begin
                        w_nextState = ERR;
                        w_done      = 1'b0;
                        w_error     = 1'b1;
                    end
`endif
                end
                BITS: begin
                    w_bitsWr = 1'b1;
                    if (w_lastByte) begin
                        w_nextState = IDLE;
                        w_done      = 1'b1;
                    end else if (r_index == 4'd15) begin
                        w_nextState = (w_newSum != 12'd0) ? VALS : TCTH;
                    end
`ifdef AQ_DJPEG_DHTSEG_CHECK_EN
                    if (((r_index == 4'd15) && ((w_newSum > 12'd256) ||
                         ((w_newSum > 12'd16) && !r_color[0]))) ||
                        (w_lastByte && !w_tableEnd)) begin
                        w_nextState = ERR;
                        w_done      = 1'b0;
                        w_error     = 1'b1;
                        w_bitsWr    = 1'b0;
                    end
`endif
                end
                VALS: begin
                    w_valsWr = 1'b1;
                    if (w_lastByte) begin
                        w_nextState = IDLE;
                        w_done      = 1'b1;
                    end else if (w_lastVal) begin
                        w_nextState = TCTH;
                    end
`ifdef AQ_DJPEG_DHTSEG_CHECK_EN
                    if (w_lastByte && !w_lastVal) begin
                        w_nextState = ERR;
                        w_done      = 1'b0;
                        w_error     = 1'b1;
                        w_valsWr    = 1'b0;
                    end
`endif
                end
                default: w_nextState = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_lenH       <= 8'd0;
            r_remaining  <= 16'd0;
            r_sum        <= 12'd0;
            r_index      <= 4'd0;
            r_count      <= 8'd0;
            r_color      <= 2'd0;
            DataInEnable <= 1'b0;
            DataInColor  <= 2'd0;
            DataInCount  <= 8'd0;
            DataIn       <= 8'd0;
            BitsEnable   <= 1'b0;
            BitsColor    <= 2'd0;
            BitsIndex    <= 4'd0;
            BitsData     <= 8'd0;
            SegDone      <= 1'b0;
            SegError     <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            BitsEnable   <= w_bitsWr;
            DataInEnable <= w_valsWr;
            SegDone      <= w_done;
            if (SegStart) begin
                SegError <= 1'b0;
            end else if (w_error) begin
                SegError <= 1'b1;
            end
            if (w_bitsWr) begin
                BitsColor <= r_color;
                BitsIndex <= r_index;
                BitsData  <= ByteData;
            end
            if (w_valsWr) begin
                DataInColor <= r_color;
                DataInCount <= r_count;
                DataIn      <= ByteData;
            end
            if (!SegStart && w_accept) begin
                case (r_state)
                    LENH: r_lenH <= ByteData;
                    LENL: r_remaining <= (w_length < 16'd2) ? 16'd0 : (w_length - 16'd2);
                    TCTH: begin
                        r_remaining <= r_remaining - 16'd1;
                        r_color     <= {ByteData[0], ByteData[4]};
                        r_sum       <= 12'd0;
                        r_index     <= 4'd0;
                    end
                    BITS: begin
                        r_remaining <= r_remaining - 16'd1;
                        r_index     <= r_index + 4'd1;
                        r_count     <= 8'd0;
                        // Symbol count beyond 256 is clipped once BITS completes
                        r_sum       <= (r_index == 4'd15) ? w_sumCap : w_newSum;
                    end
                    VALS: begin
                        r_remaining <= r_remaining - 16'd1;
                        r_count     <= r_count + 8'd1;
                    end
                    default: r_lenH <= r_lenH;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
